// File: rtl/nvdla_csb_arb_if.sv
// Bundle of the request, CSB, response and status signals around nvdla_csb_arb.
// The arbiter takes the slave modport; the requesters and the core take master.
interface nvdla_csb_arb_if #(
  parameter int DEPTH = 4
);
  localparam int OW = $clog2(DEPTH) + 2;

  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [15:0] req0_addr;
  logic [15:0] req1_addr;
  logic [31:0] req0_wdat;
  logic [31:0] req1_wdat;
  logic        req0_write;
  logic        req1_write;
  logic        req0_nposted;
  logic        req1_nposted;

  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp0_data;
  logic [31:0] rsp1_data;
  logic        rsp0_is_wr;
  logic        rsp1_is_wr;

  logic        csb2nvdla_valid;
  logic        csb2nvdla_ready;
  logic [15:0] csb2nvdla_addr;
  logic [31:0] csb2nvdla_wdat;
  logic        csb2nvdla_write;
  logic        csb2nvdla_nposted;

  logic        nvdla2csb_valid;
  logic [31:0] nvdla2csb_data;
  logic        nvdla2csb_wr_complete;

  logic          err_unexpected;
  logic [OW-1:0] outstanding;

  modport slave (
    input  req0_valid, req1_valid, req0_addr, req1_addr, req0_wdat, req1_wdat,
    input  req0_write, req1_write, req0_nposted, req1_nposted,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_is_wr, rsp1_is_wr,
    output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write,
    output csb2nvdla_nposted,
    input  csb2nvdla_ready,
    input  nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
    output err_unexpected, outstanding
  );

  modport master (
    output req0_valid, req1_valid, req0_addr, req1_addr, req0_wdat, req1_wdat,
    output req0_write, req1_write, req0_nposted, req1_nposted,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_is_wr, rsp1_is_wr,
    input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write,
    input  csb2nvdla_nposted,
    output csb2nvdla_ready,
    output nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
    input  err_unexpected, outstanding
  );
endinterface

// File: rtl/nvdla_csb_arb.sv
// Round-robin arbiter sharing the NVDLA CSB port between two requesters, with
// ID FIFOs routing in-order read data and write completions back to the issuer.
module nvdla_csb_arb #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  nvdla_csb_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = AW + 2;
  localparam int SW = AW + 2;

  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [1:0]  req_nposted;
  logic [1:0]  elig;
  logic [1:0]  req_ready;
  logic [15:0] req_addr [2];
  logic [31:0] req_wdat [2];

  assign req_valid   = {bus.req1_valid, bus.req0_valid};
  assign req_write   = {bus.req1_write, bus.req0_write};
  assign req_nposted = {bus.req1_nposted, bus.req0_nposted};
  assign req_addr[0] = bus.req0_addr;
  assign req_addr[1] = bus.req1_addr;
  assign req_wdat[0] = bus.req0_wdat;
  assign req_wdat[1] = bus.req1_wdat;

  // Index 0 is the read-ID queue, index 1 the non-posted-write-ID queue.
  logic [1:0]         push;
  logic [1:0]         pop_req;
  logic [1:0]         pop;
  logic [1:0]         full;
  logic [1:0]         head_id;
  logic [1:0][CW-1:0] fifo_cnt;
  logic [1:0][CW-1:0] fifo_cnt_d;

  logic        load;
  logic        grant;
  logic        gnt_id;
  logic        gnt_write;
  logic        gnt_np;
  logic        last_q;
  logic        ovld_q;
  logic [15:0] addr_q;
  logic [31:0] wdat_q;
  logic        write_q;
  logic        nposted_q;
  logic        err_q;
  logic [OW-1:0] outstanding_q;

  genvar gi;

  assign pop_req = {bus.nvdla2csb_wr_complete, bus.nvdla2csb_valid};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic          mem_q [DEPTH];
      logic [AW-1:0] wptr_q;
      logic [AW-1:0] rptr_q;
      logic [CW-1:0] count_q;

      // Full and empty both come from the registered count, so a same-cycle
      // pop never makes room for a push and a push never feeds a pop.
      assign full[gi]       = (count_q == CW'(DEPTH));
      assign pop[gi]        = pop_req[gi] && (count_q != '0);
      assign head_id[gi]    = mem_q[rptr_q];
      assign fifo_cnt[gi]   = count_q;
      assign fifo_cnt_d[gi] = count_q + CW'(push[gi]) - CW'(pop[gi]);

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem_q[wptr_q] <= gnt_id;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wptr_q  <= '0;
          rptr_q  <= '0;
          count_q <= '0;
        end else begin
          if (push[gi]) wptr_q <= wptr_q + 1'b1;
          if (pop[gi])  rptr_q <= rptr_q + 1'b1;
          count_q <= fifo_cnt_d[gi];
        end
      end
    end

    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi]      = req_valid[gi] &&
                             (req_write[gi] ? (!req_nposted[gi] || !full[1]) : !full[0]);
      assign req_ready[gi] = grant && (gnt_id == 1'(gi));
    end
  endgenerate

  assign load = !ovld_q || bus.csb2nvdla_ready;

  always_comb begin
    gnt_id = elig[1];
    if (elig == 2'b11) begin
      gnt_id = ~last_q;
    end
  end

  assign grant     = load && (elig != 2'b00) && !rst;
  assign gnt_write = req_write[gnt_id];
  assign gnt_np    = gnt_write && req_nposted[gnt_id];
  assign push[0]   = grant && !gnt_write;
  assign push[1]   = grant && gnt_np;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovld_q    <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      write_q   <= 1'b0;
      nposted_q <= 1'b0;
      last_q    <= 1'b1;
    end else if (load) begin
      ovld_q <= grant;
      if (grant) begin
        addr_q    <= req_addr[gnt_id];
        wdat_q    <= req_wdat[gnt_id];
        write_q   <= gnt_write;
        nposted_q <= gnt_np;
        last_q    <= gnt_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q         <= 1'b0;
      outstanding_q <= '0;
    end else begin
      if ((pop_req & ~pop) != 2'b00) err_q <= 1'b1;
      outstanding_q <= OW'(fifo_cnt_d[0]) + OW'(fifo_cnt_d[1]);
    end
  end

  logic [1:0]  rsp_vld;
  logic [1:0]  rsp_is_wr;
  logic [31:0] rsp_data [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      logic          rd_hit;
      logic          wr_hit;
      logic          skid_busy;
      logic [SW-1:0] skid_q;
      logic          vld_q;
      logic          is_wr_q;
      logic [31:0]   data_q;

      assign rd_hit    = pop[0] && (head_id[0] == 1'(gi));
      assign wr_hit    = pop[1] && (head_id[1] == 1'(gi));
      assign skid_busy = (skid_q != '0);

      // Reads go first; a completion that loses to a read, or queues behind an
      // earlier held completion, is counted in the skid and drained one per cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_q  <= '0;
          vld_q   <= 1'b0;
          is_wr_q <= 1'b0;
          data_q  <= '0;
        end else begin
          vld_q   <= rd_hit || wr_hit || skid_busy;
          is_wr_q <= !rd_hit && (wr_hit || skid_busy);
          data_q  <= rd_hit ? bus.nvdla2csb_data : 32'd0;
          if (rd_hit) begin
            skid_q <= skid_q + SW'(wr_hit);
          end else if (skid_busy) begin
            skid_q <= skid_q - SW'(1) + SW'(wr_hit);
          end
        end
      end

      assign rsp_vld[gi]   = vld_q;
      assign rsp_is_wr[gi] = is_wr_q;
      assign rsp_data[gi]  = data_q;
    end
  endgenerate

  assign bus.req0_ready        = req_ready[0];
  assign bus.req1_ready        = req_ready[1];
  assign bus.rsp0_valid        = rsp_vld[0];
  assign bus.rsp1_valid        = rsp_vld[1];
  assign bus.rsp0_data         = rsp_data[0];
  assign bus.rsp1_data         = rsp_data[1];
  assign bus.rsp0_is_wr        = rsp_is_wr[0];
  assign bus.rsp1_is_wr        = rsp_is_wr[1];
  assign bus.csb2nvdla_valid   = ovld_q;
  assign bus.csb2nvdla_addr    = addr_q;
  assign bus.csb2nvdla_wdat    = wdat_q;
  assign bus.csb2nvdla_write   = write_q;
  assign bus.csb2nvdla_nposted = nposted_q;
  assign bus.err_unexpected    = err_q;
  assign bus.outstanding       = outstanding_q;
endmodule

// File: tb/tb_nvdla_csb_arb.sv
// Directed bench for nvdla_csb_arb: reads, round-robin, FIFO full, paired
// responses, unexpected responses and reset with traffic in flight.
module tb_nvdla_csb_arb;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  nvdla_csb_arb_if #(.DEPTH(4)) bus ();

  nvdla_csb_arb #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("vec %0d %s = 0x%08h ok", nvec, tag, got);
    end
  endtask

  // Inputs change 1 ns after the edge; checks happen then or 3 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_wdat = '0;
    bus.req0_write = 0; bus.req0_nposted = 0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_wdat = '0;
    bus.req1_write = 0; bus.req1_nposted = 0;
    bus.csb2nvdla_ready = 1;
    bus.nvdla2csb_valid = 0; bus.nvdla2csb_data = '0;
    bus.nvdla2csb_wr_complete = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    check_vec("rst_csb_valid", bus.csb2nvdla_valid, 0);
    check_vec("rst_outstanding", bus.outstanding, 0);
    check_vec("rst_err", bus.err_unexpected, 0);
    check_vec("rst_rsp0_valid", bus.rsp0_valid, 0);

    // Single read from requester 0
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 16'h0040;
    #3;
    check_vec("rd_req0_ready", bus.req0_ready, 1);
    check_vec("rd_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    check_vec("rd_csb_valid", bus.csb2nvdla_valid, 1);
    check_vec("rd_csb_addr", bus.csb2nvdla_addr, 32'h0040);
    check_vec("rd_csb_write", bus.csb2nvdla_write, 0);
    check_vec("rd_outstanding", bus.outstanding, 1);
    tick();
    check_vec("rd_csb_idle", bus.csb2nvdla_valid, 0);
    bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'hDEADBEEF;
    tick();
    bus.nvdla2csb_valid = 0;
    check_vec("rd_rsp0_valid", bus.rsp0_valid, 1);
    check_vec("rd_rsp0_data", bus.rsp0_data, 32'hDEADBEEF);
    check_vec("rd_rsp0_is_wr", bus.rsp0_is_wr, 0);
    check_vec("rd_rsp1_valid", bus.rsp1_valid, 0);
    check_vec("rd_outstanding0", bus.outstanding, 0);
    tick();
    check_vec("rd_rsp0_pulse", bus.rsp0_valid, 0);

    // Round-robin with both requesters posting writes; reset makes 0 win first
    do_reset();
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 16'h1000;
    bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 16'h2000;
    for (int i = 0; i < 8; i++) begin
      #3;
      check_vec("rr_req0_ready", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
      check_vec("rr_req1_ready", bus.req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      check_vec("rr_csb_addr", bus.csb2nvdla_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
    end
    bus.csb2nvdla_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      check_vec("stall_req0_ready", bus.req0_ready, 0);
      tick();
      check_vec("stall_csb_addr", bus.csb2nvdla_addr, 32'h2000);
      check_vec("stall_csb_valid", bus.csb2nvdla_valid, 1);
    end
    bus.csb2nvdla_ready = 1;
    #3;
    check_vec("rr_resume_req0", bus.req0_ready, 1);
    tick();
    idle_inputs();
    tick();

    // Read-ID FIFO fills after 4 reads from requester 1
    bus.req1_valid = 1; bus.req1_write = 0;
    for (int k = 0; k < 4; k++) begin
      bus.req1_addr = 16'(16'h0100 + k);
      #3;
      check_vec("full_fill_ready", bus.req1_ready, 1);
      tick();
    end
    bus.req1_addr = 16'h0104;
    #3;
    check_vec("full_5th_stall", bus.req1_ready, 0);
    check_vec("full_outstanding", bus.outstanding, 4);
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_nposted = 0; bus.req0_addr = 16'h3000;
    #1;
    check_vec("full_posted_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    check_vec("full_posted_addr", bus.csb2nvdla_addr, 32'h3000);
    check_vec("full_posted_np", bus.csb2nvdla_nposted, 0);
    bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'h11110000;
    #3;
    check_vec("full_pop_cycle_stall", bus.req1_ready, 0);
    tick();
    bus.nvdla2csb_valid = 0;
    check_vec("full_rsp1_valid", bus.rsp1_valid, 1);
    check_vec("full_rsp1_data", bus.rsp1_data, 32'h11110000);
    check_vec("full_rsp0_quiet", bus.rsp0_valid, 0);
    #3;
    check_vec("full_5th_ready", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 0;
    check_vec("full_5th_addr", bus.csb2nvdla_addr, 32'h0104);
    check_vec("full_outstanding4", bus.outstanding, 4);
    for (int k = 0; k < 4; k++) begin
      bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'(32'hA0 + k);
      tick();
      check_vec("drain_rsp1_valid", bus.rsp1_valid, 1);
      check_vec("drain_rsp1_data", bus.rsp1_data, 32'(32'hA0 + k));
    end
    bus.nvdla2csb_valid = 0;
    tick();
    check_vec("drain_outstanding", bus.outstanding, 0);

    // Requester 0: a read then a non-posted write, both answered together
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 16'h0050;
    #3;
    check_vec("pair_rd_ready", bus.req0_ready, 1);
    tick();
    bus.req0_write = 1; bus.req0_nposted = 1; bus.req0_addr = 16'h0060;
    bus.req0_wdat = 32'hCAFE0001;
    #3;
    check_vec("pair_wr_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    check_vec("pair_csb_np", bus.csb2nvdla_nposted, 1);
    check_vec("pair_csb_wdat", bus.csb2nvdla_wdat, 32'hCAFE0001);
    tick();
    check_vec("pair_outstanding", bus.outstanding, 2);
    bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'h12345678;
    bus.nvdla2csb_wr_complete = 1;
    tick();
    bus.nvdla2csb_valid = 0; bus.nvdla2csb_wr_complete = 0;
    check_vec("pair_t1_valid", bus.rsp0_valid, 1);
    check_vec("pair_t1_data", bus.rsp0_data, 32'h12345678);
    check_vec("pair_t1_is_wr", bus.rsp0_is_wr, 0);
    tick();
    check_vec("pair_t2_valid", bus.rsp0_valid, 1);
    check_vec("pair_t2_is_wr", bus.rsp0_is_wr, 1);
    check_vec("pair_t2_data", bus.rsp0_data, 0);
    tick();
    check_vec("pair_t3_valid", bus.rsp0_valid, 0);

    // Different IDs answered together: both respond at once
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_nposted = 0; bus.req0_addr = 16'h0070;
    bus.req1_valid = 1; bus.req1_write = 1; bus.req1_nposted = 1; bus.req1_addr = 16'h0080;
    #3;
    check_vec("split_first_req1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 0;
    #3;
    check_vec("split_second_req0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    tick();
    bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'h55AA55AA;
    bus.nvdla2csb_wr_complete = 1;
    tick();
    bus.nvdla2csb_valid = 0; bus.nvdla2csb_wr_complete = 0;
    check_vec("split_rsp0_data", bus.rsp0_data, 32'h55AA55AA);
    check_vec("split_rsp0_valid", bus.rsp0_valid, 1);
    check_vec("split_rsp1_valid", bus.rsp1_valid, 1);
    check_vec("split_rsp1_is_wr", bus.rsp1_is_wr, 1);
    tick();

    // Unexpected read return
    check_vec("unexp_pre_err", bus.err_unexpected, 0);
    bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'h77777777;
    tick();
    bus.nvdla2csb_valid = 0;
    check_vec("unexp_rsp0", bus.rsp0_valid, 0);
    check_vec("unexp_rsp1", bus.rsp1_valid, 0);
    check_vec("unexp_err", bus.err_unexpected, 1);
    tick();
    tick();
    check_vec("unexp_err_sticky", bus.err_unexpected, 1);

    // Reset with three reads in flight
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 16'h0020;
    tick();
    tick();
    tick();
    bus.req0_valid = 0;
    check_vec("mid_outstanding3", bus.outstanding, 3);
    do_reset();
    check_vec("mid_outstanding", bus.outstanding, 0);
    check_vec("mid_csb_valid", bus.csb2nvdla_valid, 0);
    check_vec("mid_csb_addr", bus.csb2nvdla_addr, 0);
    check_vec("mid_err", bus.err_unexpected, 0);
    bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'h99999999;
    tick();
    bus.nvdla2csb_valid = 0;
    check_vec("mid_stale_rsp0", bus.rsp0_valid, 0);
    check_vec("mid_stale_err", bus.err_unexpected, 1);
    bus.req0_valid = 1; bus.req0_addr = 16'h0090;
    #3;
    check_vec("mid_new_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    check_vec("mid_new_addr", bus.csb2nvdla_addr, 32'h0090);
    bus.nvdla2csb_valid = 1; bus.nvdla2csb_data = 32'h0BADF00D;
    tick();
    bus.nvdla2csb_valid = 0;
    check_vec("mid_new_rsp0_valid", bus.rsp0_valid, 1);
    check_vec("mid_new_rsp0_data", bus.rsp0_data, 32'h0BADF00D);
    check_vec("mid_new_outstanding", bus.outstanding, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
